// File: rtl/restoring_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider_if
//  Description : Handshake/data bundle between a divider client (master) and
//                the restoring divider (slave).
//                  start        - request a division (master -> slave)
//                  dividend     - 2*DIV_Size-bit unsigned dividend
//                  divisor      - DIV_Size-bit unsigned divisor
//                  busy         - divider is in CALC or DONE
//                  done         - one-cycle result-valid pulse
//                  quotient     - DIV_Size-bit result
//                  remainder    - DIV_Size-bit result
//                  div_by_zero  - divisor was zero
//                  overflow     - quotient would not fit in DIV_Size bits
//  Revision    : 1.0 - initial release
// ============================================================================
interface restoring_divider_if #(
    parameter int DIV_Size = 32
);
    logic                    start;
    logic [2*DIV_Size-1:0]   dividend;
    logic [DIV_Size-1:0]     divisor;
    logic                    busy;
    logic                    done;
    logic [DIV_Size-1:0]     quotient;
    logic [DIV_Size-1:0]     remainder;
    logic                    div_by_zero;
    logic                    overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider
//  Description : Unsigned 2N/N restoring divider, one quotient bit per clock.
//                Ports:
//                  clk  - clock, rising edge
//                  rst  - asynchronous active-low reset
//                  bus  - restoring_divider_if.slave (start/operands in,
//                         busy/done/results/error flags out, all registered)
//                Error cases (divisor zero, quotient overflow) finish in one
//                cycle; normal divisions take DIV_Size CALC cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
    parameter int DIV_Size = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    restoring_divider_if.slave     bus
);

    localparam int         c_CNT_W  = (DIV_Size > 1) ? $clog2(DIV_Size) : 1;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic [DIV_Size-1:0]   r_divisor;
    logic [DIV_Size:0]     r_prem;      // partial remainder, one guard bit
    logic [DIV_Size-1:0]   r_qreg;      // dividend low half shifting into quotient
    logic                  r_busy;
    logic                  r_done;
    logic [DIV_Size-1:0]   r_quotient;
    logic [DIV_Size-1:0]   r_remainder;
    logic                  r_div_by_zero;
    logic                  r_overflow;

    logic [DIV_Size+1:0]   w_shift;
    logic [DIV_Size+1:0]   w_trial;
    logic                  w_neg;
    logic [DIV_Size:0]     w_prem_next;
    logic [DIV_Size-1:0]   w_q_next;
    logic                  w_hi_ge;

    // One restoring step. The shifted remainder is kept one bit wider than
    // the partial remainder so the trial subtraction's sign bit is explicit.
    always_comb begin
        w_shift     = {r_prem, r_qreg[DIV_Size-1]};
        w_trial     = w_shift - {2'b00, r_divisor};
        w_neg       = w_trial[DIV_Size+1];
        w_prem_next = w_neg ? w_shift[DIV_Size:0] : w_trial[DIV_Size:0];
        w_q_next    = r_qreg << 1;
        w_q_next[0] = ~w_neg;
    end

    // High half >= divisor means the quotient needs more than DIV_Size bits.
    assign w_hi_ge = (bus.dividend[2*DIV_Size-1:DIV_Size] >= bus.divisor);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_S_IDLE;
            r_count       <= '0;
            r_divisor     <= '0;
            r_prem        <= '0;
            r_qreg        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_divisor     <= bus.divisor;
                        r_prem        <= {1'b0, bus.dividend[2*DIV_Size-1:DIV_Size]};
                        r_qreg        <= bus.dividend[DIV_Size-1:0];
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_state       <= c_S_DONE;
                            r_done        <= 1'b1;
                            r_div_by_zero <= 1'b1;
                            r_quotient    <= '1;
                            r_remainder   <= bus.dividend[DIV_Size-1:0];
                        end else if (w_hi_ge) begin
                            r_state     <= c_S_DONE;
                            r_done      <= 1'b1;
                            r_overflow  <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= '0;
                        end else begin
                            r_state <= c_S_CALC;
                            r_count <= c_CNT_W'(DIV_Size - 1);
                        end
                    end
                end
                c_S_CALC: begin
                    r_prem <= w_prem_next;
                    r_qreg <= w_q_next;
                    if (r_count == '0) begin
                        r_state     <= c_S_DONE;
                        r_done      <= 1'b1;
                        r_quotient  <= w_q_next;
                        r_remainder <= w_prem_next[DIV_Size-1:0];
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restoring_divider
//  Description : Self-checking bench for restoring_divider (DIV_Size = 32).
//                Directed vector table plus hand-written sequences for held
//                start, back-to-back acceptance and mid-calculation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

    localparam int c_N = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    restoring_divider_if #(.DIV_Size(c_N)) bus ();

    restoring_divider #(.DIV_Size(c_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [63:0]  dividend;
        logic [31:0]  divisor;
        logic [31:0]  exp_q;
        logic [31:0]  exp_r;
        logic         exp_dz;
        logic         exp_ov;
        int           exp_lat;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge that follows
    // the done cycle, with the divider back in IDLE.
    task automatic run_vec(input vec_t v);
        int lat;
        bit seen;
        bus.dividend = v.dividend;
        bus.divisor  = v.divisor;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (k == 1) check({v.name, " busy_calc"}, 64'(bus.busy), 64'd1);
            @(posedge clk); #1;
            lat++;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no done within 40 cycles", v.name);
        end else begin
            check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
            check({v.name, " quotient"}, 64'(bus.quotient), 64'(v.exp_q));
            check({v.name, " remainder"}, 64'(bus.remainder), 64'(v.exp_r));
            check({v.name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(v.exp_dz));
            check({v.name, " overflow"}, 64'(bus.overflow), 64'(v.exp_ov));
            check({v.name, " busy_done"}, 64'(bus.busy), 64'd1);
        end
        @(posedge clk); #1;
        check({v.name, " done_pulse"}, 64'(bus.done), 64'd0);
        check({v.name, " idle_busy"}, 64'(bus.busy), 64'd0);
        check({v.name, " hold_q"}, 64'(bus.quotient), 64'(v.exp_q));
        check({v.name, " hold_r"}, 64'(bus.remainder), 64'(v.exp_r));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pulses;
        bit seen;

        vecs[0]  = '{"d100_7",   64'd100,                   32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 32};
        vecs[1]  = '{"d6hi_7",   64'h00000006_00000000,     32'd7,          32'hDB6DB6DB,   32'd3,          1'b0, 1'b0, 32};
        vecs[2]  = '{"dmax",     64'hFFFFFFFE_00000001,     32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 32};
        vecs[3]  = '{"ovf7",     64'h00000007_00000000,     32'd7,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b1, 0};
        vecs[4]  = '{"dz",       64'h12345678_9ABCDEF0,     32'd0,          32'hFFFFFFFF,   32'h9ABCDEF0,   1'b1, 1'b0, 0};
        vecs[5]  = '{"zero_5",   64'd0,                     32'd5,          32'd0,          32'd0,          1'b0, 1'b0, 32};
        vecs[6]  = '{"lo_1",     64'h00000000_FFFFFFFF,     32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 32};
        vecs[7]  = '{"ovf1",     64'h00000001_00000000,     32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b1, 0};
        vecs[8]  = '{"eq1000",   64'd1000,                  32'd1000,       32'd1,          32'd0,          1'b0, 1'b0, 32};
        vecs[9]  = '{"lt1000",   64'd999,                   32'd1000,       32'd0,          32'd999,        1'b0, 1'b0, 32};
        vecs[10] = '{"lo_16",    64'h00000000_FFFFFFFF,     32'h10,         32'h0FFFFFFF,   32'hF,          1'b0, 1'b0, 32};
        vecs[11] = '{"hi1_2",    64'h00000001_00000000,     32'd2,          32'h80000000,   32'd0,          1'b0, 1'b0, 32};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst quotient", 64'(bus.quotient), 64'd0);
        check("rst remainder", 64'(bus.remainder), 64'd0);
        check("rst div_by_zero", 64'(bus.div_by_zero), 64'd0);
        check("rst overflow", 64'(bus.overflow), 64'd0);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        // Directed table, issued back to back.
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // start held high while operands change during CALC.
        bus.dividend = 64'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            bus.dividend = 64'(k * 977 + 5);
            bus.divisor  = 32'(k + 2);
            @(posedge clk); #1;
            lat++;
        end
        check("held latency", 64'(seen ? lat : -1), 64'd32);
        check("held quotient", 64'(bus.quotient), 64'd14);
        check("held remainder", 64'(bus.remainder), 64'd2);

        // start still high through DONE: ignored there, accepted in IDLE next.
        bus.dividend = 64'd200;
        bus.divisor  = 32'd9;
        @(posedge clk); #1;
        check("held idle busy", 64'(bus.busy), 64'd0);
        check("held idle done", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        check("held reaccept busy", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;

        // Abort with reset in the middle of CALC.
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort quotient", 64'(bus.quotient), 64'd0);
        check("abort remainder", 64'(bus.remainder), 64'd0);
        check("abort div_by_zero", 64'(bus.div_by_zero), 64'd0);
        check("abort overflow", 64'(bus.overflow), 64'd0);
        #3 rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) pulses++;
        end
        check("abort no_done", 64'(pulses), 64'd0);

        // First start after reset is accepted immediately.
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
